// File: rtl/seg_display_decoder_if.sv
// Multiplexed 7-segment scan bus: segment lines plus one-hot digit enables.
// The master drives the bus; the decoder watches it through the slave modport.
interface seg_display_decoder_if;
    logic [7:0] segments;  // [7]=dot, [6:0]=gfedcba
    logic [3:0] digits;    // one-hot when a digit is being driven

    modport master (
        output segments,
        output digits
    );

    modport slave (
        input segments,
        input digits
    );
endinterface

// File: rtl/seg_display_decoder.sv
// Rebuilds per-digit BCD, dot, blank and error state from a multiplexed 4-digit 7-segment bus.
// Optional build macro SEG_DECODE_HEX_EN: also accept the A..F glyphs as legal digits.
module seg_display_decoder #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned BLANK_TIMEOUT  = 4096,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    seg_display_decoder_if.slave i_Bus,
    output logic [15:0]          o_Bcd,
    output logic [3:0]           o_Dots,
    output logic [3:0]           o_Blank,
    output logic [3:0]           o_Error,
    output logic                 o_Frame_Stb
);
    localparam int unsigned CntW = $clog2(STABLE_CYCLES);
    localparam int unsigned TmrW = $clog2(BLANK_TIMEOUT + 1);

    localparam logic [CntW-1:0] CntMax  = CntW'(STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] CntFire = CntW'(STABLE_CYCLES - 2);
    localparam logic [TmrW-1:0] TmrMax  = TmrW'(BLANK_TIMEOUT);
    localparam logic [TmrW-1:0] TmrLast = TmrW'(BLANK_TIMEOUT - 1);
    localparam logic [7:0]      SegInv  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [11:0]     r_sample;
    logic [11:0]     r_prev;
    logic [CntW-1:0] r_cnt;
    logic [15:0]     r_bcd;
    logic [3:0]      r_dots;
    logic [3:0]      r_blank;
    logic [3:0]      r_error;
    logic [3:0]      r_seen;
    logic            r_frame_stb;
    logic [TmrW-1:0] r_timer [4];

    logic       w_stable;
    logic       w_one_hot;
    logic       w_capture;
    logic [3:0] w_cap_vec;
    logic [3:0] w_blank_rise;
    logic [3:0] w_events;
    logic [3:0] w_dec_nib;
    logic       w_dec_err;

    // Input register and stability counter; the counter parks at CntMax so a held
    // sample is captured exactly once.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_sample <= '0;
            r_prev   <= '0;
            r_cnt    <= '0;
        end else begin
            r_sample <= {i_Bus.digits, i_Bus.segments ^ SegInv};
            r_prev   <= r_sample;
            if (!w_stable) begin
                r_cnt <= '0;
            end else if (r_cnt != CntMax) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_stable  = (r_sample == r_prev);
    assign w_one_hot = $onehot(r_sample[11:8]);
    assign w_capture = w_stable && (r_cnt == CntFire) && w_one_hot;
    assign w_cap_vec = w_capture ? r_sample[11:8] : 4'b0000;

    always_comb begin
        w_dec_nib = 4'hF;
        w_dec_err = 1'b0;
        case (r_sample[6:0])
            7'b0111111: w_dec_nib = 4'h0;
            7'b0000110: w_dec_nib = 4'h1;
            7'b1011011: w_dec_nib = 4'h2;
            7'b1001111: w_dec_nib = 4'h3;
            7'b1100110: w_dec_nib = 4'h4;
            7'b1101101: w_dec_nib = 4'h5;
            7'b1111101: w_dec_nib = 4'h6;
            7'b0000111: w_dec_nib = 4'h7;
            7'b1111111: w_dec_nib = 4'h8;
            7'b1101111: w_dec_nib = 4'h9;
`ifdef SEG_DECODE_HEX_EN
            7'b1110111: w_dec_nib = 4'hA;
            7'b1111100: w_dec_nib = 4'hB;
            7'b0111001: w_dec_nib = 4'hC;
            7'b1011110: w_dec_nib = 4'hD;
            7'b1111001: w_dec_nib = 4'hE;
            7'b1110001: w_dec_nib = 4'hF;
`endif
            default:    w_dec_err = 1'b1;
        endcase
    end

    // A capture on the same cycle as a timeout wins, so the rise is masked here.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_blank_rise[k] = !w_cap_vec[k] && (r_timer[k] == TmrLast);
        end
    end

    assign w_events = w_cap_vec | w_blank_rise;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_bcd   <= '0;
            r_dots  <= '0;
            r_blank <= '0;
            r_error <= '0;
            for (int k = 0; k < 4; k++) begin
                r_timer[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_cap_vec[k]) begin
                    r_timer[k]     <= '0;
                    r_blank[k]     <= 1'b0;
                    r_bcd[4*k +: 4] <= w_dec_nib;
                    r_dots[k]      <= r_sample[7];
                    r_error[k]     <= w_dec_err;
                end else if (r_timer[k] != TmrMax) begin
                    r_timer[k] <= r_timer[k] + 1'b1;
                    if (w_blank_rise[k]) begin
                        r_blank[k] <= 1'b1;
                    end
                end
            end
        end
    end

    // Events landing on the strobe cycle seed the next frame's mask.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_seen      <= '0;
            r_frame_stb <= 1'b0;
        end else begin
            r_frame_stb <= (r_seen == 4'hF);
            r_seen      <= ((r_seen == 4'hF) ? 4'h0 : r_seen) | w_events;
        end
    end

    assign o_Bcd       = r_bcd;
    assign o_Dots      = r_dots;
    assign o_Blank     = r_blank;
    assign o_Error     = r_error;
    assign o_Frame_Stb = r_frame_stb;
endmodule
